// File: rtl/digit_entry_ctrl_pkg.sv
// Shared constants, state encoding and digit helpers for the digit entry controller.
package digit_entry_ctrl_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;
    localparam int         NUM_SLOTS   = 12;
    localparam int         EDIT_SLOTS  = 6;
    localparam int         EDIT_BASE   = 6;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_SUBMIT = 2'd2;

    // Editable digits live in 0..9; anything out of range snaps back into range.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic [2:0] cursor_inc(input logic [2:0] c);
        return (c >= 3'(EDIT_SLOTS - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [2:0] cursor_dec(input logic [2:0] c);
        return (c == 3'd0 || c > 3'(EDIT_SLOTS - 1)) ? 3'(EDIT_SLOTS - 1) : c - 3'd1;
    endfunction

    // Bottom-row slot EDIT_BASE+c sits at bits [23-4c:20-4c] of the display word.
    function automatic logic [3:0] get_edit_digit(input logic [47:0] w, input logic [2:0] c);
        logic [3:0] d;
        d = 4'h0;
        for (int i = 0; i < EDIT_SLOTS; i++) begin
            if (c == 3'(i)) d = w[23-4*i -: 4];
        end
        return d;
    endfunction

    function automatic logic [47:0] set_edit_digit(input logic [47:0] w, input logic [2:0] c,
                                                   input logic [3:0] d);
        logic [47:0] r;
        r = w;
        for (int i = 0; i < EDIT_SLOTS; i++) begin
            if (c == 3'(i)) r[23-4*i -: 4] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_entry_ctrl_blink.sv
// Frame-counted blink phase generator for the edit cursor.
module blink_timer #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] count_q;
    logic          phase_q;

    // Count frames while enabled; restart or disable pins the phase visible and the count at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else if (!enable || restart) begin
            count_q <= '0;
            phase_q <= 1'b1;
        end else if (frame_start) begin
            if (count_q == LAST) begin
                count_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/digit_entry_ctrl.sv
// Owns the 12-digit display word: loads a puzzle, edits the bottom row, submits the entry.
module digit_entry_ctrl
    import digit_entry_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_confirm,
    input  logic        puzzle_valid,
    input  logic [15:0] puzzle_digits,
    output logic        puzzle_ready,
    output logic [47:0] numbers_concat,
    output logic [2:0]  cursor,
    output logic        blink_on,
    output logic        submit_valid,
    output logic [23:0] submit_digits,
    input  logic        submit_ready
);

    logic [1:0]  state_q, state_d;
    logic [47:0] shadow_q, shadow_d;
    logic [2:0]  cursor_q, cursor_d;
    logic        sub_valid_q, sub_valid_d;
    logic [23:0] sub_digits_q, sub_digits_d;
    logic [47:0] display_q;
    logic [3:0]  cur_digit;
    logic        action;
    logic        phase;

    assign cur_digit = get_edit_digit(shadow_q, cursor_q);

    // Next-state: puzzle load, one prioritised edit action per cycle, submit handshake.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        cursor_d     = cursor_q;
        sub_valid_d  = sub_valid_q;
        sub_digits_d = sub_digits_q;
        action       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (puzzle_valid) begin
                    shadow_d = {puzzle_digits, BLANK_DIGIT, BLANK_DIGIT, 24'h0};
                    cursor_d = 3'd0;
                    state_d  = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (btn_confirm) begin
                    action       = 1'b1;
                    sub_valid_d  = 1'b1;
                    sub_digits_d = shadow_q[23:0];
                    state_d      = ST_SUBMIT;
                end else if (btn_up) begin
                    action   = 1'b1;
                    shadow_d = set_edit_digit(shadow_q, cursor_q, digit_inc(cur_digit));
                end else if (btn_down) begin
                    action   = 1'b1;
                    shadow_d = set_edit_digit(shadow_q, cursor_q, digit_dec(cur_digit));
                end else if (btn_left) begin
                    action   = 1'b1;
                    cursor_d = cursor_dec(cursor_q);
                end else if (btn_right) begin
                    action   = 1'b1;
                    cursor_d = cursor_inc(cursor_q);
                end
            end
            ST_SUBMIT: begin
                if (submit_ready) begin
                    sub_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= {NUM_SLOTS{BLANK_DIGIT}};
            cursor_q     <= 3'd0;
            sub_valid_q  <= 1'b0;
            sub_digits_q <= 24'h0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            cursor_q     <= cursor_d;
            sub_valid_q  <= sub_valid_d;
            sub_digits_q <= sub_digits_d;
        end
    end

    // Commit the pre-update shadow and phase to the renderer only at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q <= {NUM_SLOTS{BLANK_DIGIT}};
        end else if (frame_start) begin
            display_q <= phase ? shadow_q : set_edit_digit(shadow_q, cursor_q, BLANK_DIGIT);
        end
    end

    // Confirm also counts as an action so the phase is forced visible on SUBMIT entry.
    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .enable      (state_q == ST_EDIT),
        .restart     (action),
        .phase       (phase)
    );

    assign puzzle_ready   = (state_q == ST_IDLE);
    assign numbers_concat = display_q;
    assign cursor         = cursor_q;
    assign blink_on       = phase;
    assign submit_valid   = sub_valid_q;
    assign submit_digits  = sub_digits_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Scoreboard bench: frame commits and submit handshakes checked against queued expectations.
module tb_digit_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic        btn_confirm = 1'b0;
    logic        puzzle_valid = 1'b0;
    logic [15:0] puzzle_digits = 16'h0;
    logic        puzzle_ready;
    logic [47:0] numbers_concat;
    logic [2:0]  cursor;
    logic        blink_on;
    logic        submit_valid;
    logic [23:0] submit_digits;
    logic        submit_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] disp_q[$];
    logic [23:0] sub_q[$];

    // Button encoding {confirm, up, down, left, right}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_CONF = 5'b10000;
    localparam logic [4:0] B_UP   = 5'b01000;
    localparam logic [4:0] B_DOWN = 5'b00100;
    localparam logic [4:0] B_LEFT = 5'b00010;
    localparam logic [4:0] B_RGHT = 5'b00001;

    digit_entry_ctrl #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_confirm    (btn_confirm),
        .puzzle_valid   (puzzle_valid),
        .puzzle_digits  (puzzle_digits),
        .puzzle_ready   (puzzle_ready),
        .numbers_concat (numbers_concat),
        .cursor         (cursor),
        .blink_on       (blink_on),
        .submit_valid   (submit_valid),
        .submit_digits  (submit_digits),
        .submit_ready   (submit_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; returns #1 after the sampling edge.
    task automatic drive(input logic [4:0] btns, input logic fs);
        @(negedge clk);
        {btn_confirm, btn_up, btn_down, btn_left, btn_right} = btns;
        frame_start = fs;
        @(posedge clk);
        #1;
        {btn_confirm, btn_up, btn_down, btn_left, btn_right} = B_NONE;
        frame_start = 1'b0;
    endtask

    task automatic frame(input logic [47:0] exp);
        disp_q.push_back(exp);
        drive(B_NONE, 1'b1);
    endtask

    task automatic offer(input logic [15:0] digits);
        @(negedge clk);
        puzzle_valid  = 1'b1;
        puzzle_digits = digits;
        @(posedge clk);
        #1;
        puzzle_valid = 1'b0;
        check("puzzle_ready_drop", {47'h0, puzzle_ready}, 48'h0);
    endtask

    // Monitor: pops an expectation on every commit and every accepted submit.
    initial begin
        logic        fs, hs;
        logic [23:0] sd;
        forever begin
            @(posedge clk);
            fs = frame_start & rst_n;
            hs = submit_valid & submit_ready & rst_n;
            sd = submit_digits;
            #1;
            if (fs) begin
                if (disp_q.size() == 0) check("unexpected_commit", numbers_concat, 48'hX);
                else check("commit", numbers_concat, disp_q.pop_front());
            end
            if (hs) begin
                if (sub_q.size() == 0) check("unexpected_submit", {24'h0, sd}, 48'hX);
                else check("submit_digits", {24'h0, sd}, {24'h0, sub_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_display", numbers_concat, 48'hFFFF_FFFF_FFFF);
        check("rst_cursor", {45'h0, cursor}, 48'h0);
        check("rst_blink", {47'h0, blink_on}, 48'h1);
        check("rst_submit_valid", {47'h0, submit_valid}, 48'h0);
        check("rst_submit_digits", {24'h0, submit_digits}, 48'h0);
        check("rst_puzzle_ready", {47'h0, puzzle_ready}, 48'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load puzzle, first commit (counter 0 -> 1)
        offer(16'h1234);
        frame(48'h1234FF000000);

        // 3x up, right, down; commit with counter 0 -> 1
        repeat (3) drive(B_UP, 1'b0);
        drive(B_RGHT, 1'b0);
        drive(B_DOWN, 1'b0);
        check("cursor_after_right", {45'h0, cursor}, 48'h1);
        frame(48'h1234FF390000);

        // Second idle frame commits old phase, then toggles
        frame(48'h1234FF390000);
        check("blink_toggled", {47'h0, blink_on}, 48'h0);
        frame(48'h1234FF3F0000);
        check("blink_still_off", {47'h0, blink_on}, 48'h0);

        // Up on 9 wraps to 0 and restores the cursor digit
        drive(B_UP, 1'b0);
        check("blink_restored", {47'h0, blink_on}, 48'h1);
        frame(48'h1234FF300000);

        // Cursor wrap 0 -> 5, then up+left applies only the increment
        drive(B_LEFT, 1'b0);
        check("cursor_left", {45'h0, cursor}, 48'h0);
        drive(B_LEFT, 1'b0);
        check("cursor_wrap_left", {45'h0, cursor}, 48'h5);
        drive(B_UP | B_LEFT, 1'b0);
        check("cursor_priority", {45'h0, cursor}, 48'h5);

        // frame_start alongside a button: old shadow now, edit on the next frame
        disp_q.push_back(48'h1234FF300001);
        drive(B_UP, 1'b1);
        frame(48'h1234FF300002);

        // Confirm and hold off acceptance
        sub_q.push_back(24'h300002);
        drive(B_CONF, 1'b0);
        check("submit_valid_set", {47'h0, submit_valid}, 48'h1);
        for (int i = 0; i < 5; i++) begin
            drive(B_UP | B_RGHT, 1'b0);
            check("submit_hold_valid", {47'h0, submit_valid}, 48'h1);
            check("submit_hold_digits", {24'h0, submit_digits}, 48'h300002);
        end
        frame(48'h1234FF300002);
        @(negedge clk);
        submit_ready = 1'b1;
        @(posedge clk);
        #1;
        submit_ready = 1'b0;
        check("submit_valid_clear", {47'h0, submit_valid}, 48'h0);
        check("idle_ready", {47'h0, puzzle_ready}, 48'h1);

        // Buttons in IDLE have no effect
        drive(B_UP, 1'b0);
        drive(B_RGHT, 1'b0);
        check("idle_cursor", {45'h0, cursor}, 48'h5);
        frame(48'h1234FF300002);

        // Unchecked puzzle digits, confirm, then reset mid-SUBMIT
        offer(16'hA0B9);
        frame(48'hA0B9FF000000);
        drive(B_CONF, 1'b0);
        check("submit_valid_2", {47'h0, submit_valid}, 48'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {47'h0, submit_valid}, 48'h0);
        check("async_rst_display", numbers_concat, 48'hFFFF_FFFF_FFFF);
        check("async_rst_ready", {47'h0, puzzle_ready}, 48'h1);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) @(negedge clk);
        check("disp_queue_empty", 48'(disp_q.size()), 48'h0);
        check("sub_queue_empty", 48'(sub_q.size()), 48'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Controller that owns the 12-digit display word feeding the screen renderer.
- Loads a 4-digit 24-game puzzle into the top row, lets the player edit 6 digits in the bottom row with cursor buttons, and submits the entry downstream.
- Display updates are committed only on frame_start, so the renderer never sees a mid-frame change; the cursor digit blinks at a frame-counted rate.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period (must be >= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- frame_start  in  1  single-cycle pulse at start of vertical blank.
- btn_left, btn_right, btn_up, btn_down, btn_confirm  in  1 each  debounced single-cycle button pulses.
- puzzle_valid  in  1  puzzle offer.
- puzzle_digits  in  16  4 digits; [15:12] goes to slot 0.
- puzzle_ready  out  1  high in IDLE.
- numbers_concat  out  48  display word; slot k occupies [47-4k:44-4k]; slots 0-5 are the top row, 6-11 the bottom row.
- cursor  out  3  edit position 0..5 (bottom-row slot 6+cursor).
- blink_on  out  1  current blink phase; 1 means the cursor digit is visible.
- submit_valid  out  1  entry offer.
- submit_digits  out  24  bottom-row digits; [23:20] is slot 6.
- submit_ready  in  1  downstream accept.

Behaviour:
- Code 4'hF is BLANK; the renderer draws nothing for codes 10-15.
- Reset values:
  - numbers_concat = 48'hFFFF_FFFF_FFFF; the internal shadow word is the same value.
  - cursor = 0, blink_on = 1, submit_valid = 0, submit_digits = 0, puzzle_ready = 1.
  - state = IDLE, frame counter = 0.
- FSM IDLE -> EDIT:
  - Triggered by puzzle_valid & puzzle_ready.
  - Next cycle, shadow = {puzzle_digits, BLANK, BLANK, six 4'h0}, cursor = 0, blink_on = 1, counter = 0.
  - Puzzle digits are copied unchecked; values above 9 render blank.
- EDIT:
  - At most one action per cycle. Priority: confirm > up > down > left > right.
  - up: cursor digit +1, wrapping 9 -> 0.
  - down: cursor digit -1, wrapping 0 -> 9.
  - Editable digits are always 0..9.
  - left: cursor -1, wrapping 0 -> 5.
  - right: cursor +1, wrapping 5 -> 0.
  - Any up/down/left/right action forces blink_on = 1 and counter = 0.
  - Shadow and cursor update in the cycle after the pulse (1-cycle latency).
  - confirm -> SUBMIT. On entry: submit_digits = shadow[23:0], submit_valid = 1, blink_on forced to 1.
- SUBMIT:
  - submit_valid is held with submit_digits stable until submit_ready is sampled high.
  - On acceptance: submit_valid = 0 next cycle, state -> IDLE.
  - Shadow is kept, so the display persists until the next puzzle.
  - Buttons are ignored.
- IDLE: buttons are ignored; puzzle_ready = 1. puzzle_valid is ignored outside IDLE.
- Blink (EDIT only):
  - On frame_start, counter increments.
  - When the counter equals BLINK_FRAMES-1 at a frame_start, it returns to 0 and blink_on toggles.
  - In IDLE and SUBMIT, blink_on = 1 and the counter holds at 0.
- Display commit:
  - On a cycle with frame_start = 1, numbers_concat <= shadow, with slot 6+cursor replaced by BLANK when blink_on = 0.
  - Both shadow and blink_on are the pre-update values of that cycle.
  - numbers_concat changes on no other cycle.
- Simultaneous events:
  - frame_start with a button: the commit uses the old shadow; the edit is shown on the next frame_start.
  - frame_start with a blink toggle: the commit uses the old phase.
  - frame_start with an action reset: the action reset wins the counter and phase.
- Reset mid-operation: everything returns to reset values immediately, including during SUBMIT; a pending submit is dropped.
- Arithmetic: the digit wrap uses 4-bit compare-and-select, with no modulo operator. The counter width is clog2(BLINK_FRAMES) with a minimum of 1.

Decomposition:
- Shared package: BLANK_DIGIT = 4'hF, NUM_SLOTS = 12, EDIT_SLOTS = 6, EDIT_BASE = 6, state encoding {IDLE, EDIT, SUBMIT}.
- One sub-module, blink_timer.
  - Inputs: clk, rst_n, frame_start, enable, restart.
  - Output: phase.
  - Parameter: BLINK_FRAMES.

Test Plan:
- Reset, then puzzle 16'h1234 offered, then frame_start -> numbers_concat = 48'h1234FF000000; puzzle_ready drops 1 cycle after the handshake.
- In EDIT, 3x up, right, down, then frame_start -> bottom row 3,9,0,0,0,0; numbers_concat = 48'h1234FF390000; cursor = 1.
- With cursor = 0, left -> cursor = 5. With the digit at 9, up -> 0. up+left in the same cycle -> only the increment applies.
- BLINK_FRAMES = 2, no buttons -> blink_on toggles on every 2nd frame_start. The next commit then shows slot 6+cursor as F, and a button press restores the digit at the following commit.
- confirm with submit_ready low for 5 cycles -> submit_valid stays high and submit_digits is stable; ready high -> IDLE, puzzle_ready = 1, later buttons have no effect.
- rst_n asserted during SUBMIT -> submit_valid = 0 and numbers_concat = all F asynchronously; frame_start during a button pulse -> the change appears one frame later.
